// File: rtl/imem_boot_loader.sv
// Boot-loaded instruction RAM for rv64_core: filled over a valid/ready stream, then serves combinational fetches.
// Optional load checksum stage (CHECK/ERROR states, ld_error port) built with `define IMEM_LOAD_CHECKSUM_EN.
module imem_boot_loader #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned ADDR_W    = $clog2(DEPTH),
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter logic [31:0] NOP_INSN  = 32'h00000013
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_count,
  input  logic              ld_valid,
  input  logic [31:0]       ld_data,
  output logic              ld_ready,
  output logic              busy,
  output logic              core_reset,
`ifdef IMEM_LOAD_CHECKSUM_EN
  output logic              ld_error,
`endif
  input  logic [63:0]       imem_addr,
  output logic [31:0]       imem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
`ifdef IMEM_LOAD_CHECKSUM_EN
    S_CHECK,
    S_ERROR,
`endif
    S_RUN
  } state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] len_q, len_d;
  logic            wr_en;
  logic            can_start;
  logic [31:0]     mem [DEPTH];
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [31:0]     sum_q, sum_d;
`endif

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    len_d      = len_q;
    wr_en      = 1'b0;
    can_start  = 1'b0;
    ld_ready   = 1'b0;
    busy       = 1'b0;
    core_reset = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_d      = sum_q;
    ld_error   = 1'b0;
`endif
    case (state_q)
      S_IDLE: can_start = 1'b1;
      S_LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_d    = sum_q + ld_data;
          if (wr_ptr_q == len_q - 1'b1) state_d = S_CHECK;
`else
          if (wr_ptr_q == len_q - 1'b1) state_d = S_RUN;
`endif
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      S_CHECK: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        if (ld_valid) state_d = (ld_data == sum_q) ? S_RUN : S_ERROR;
      end
      S_ERROR: begin
        ld_error  = 1'b1;
        can_start = 1'b1;
      end
`endif
      S_RUN: begin
        core_reset = 1'b0;
        can_start  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // A new load clamps its length to the RAM size; a zero-length load skips straight past LOAD.
    if (can_start && ld_start) begin
      len_d    = (ld_count > DEPTH_W) ? DEPTH_W : ld_count;
      wr_ptr_d = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_d    = '0;
      state_d  = (ld_count == '0) ? S_CHECK : S_LOAD;
`else
      state_d  = (ld_count == '0) ? S_RUN : S_LOAD;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      len_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      len_q    <= len_d;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  // RAM has no reset: contents survive a reset and are hidden until the next load completes.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= ld_data;
  end

  logic [63:0] off;
  assign off = imem_addr - BASE_ADDR;

  always_comb begin
    imem_rdata = NOP_INSN;
    if (state_q == S_RUN && off[1:0] == 2'b00 && off[63:ADDR_W+2] == '0)
      imem_rdata = mem[off[ADDR_W+1:2]];
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader against a word-array reference model of the loaded image.
module tb_imem_boot_loader;
  localparam int          DEPTH  = 1024;
  localparam int          ADDR_W = $clog2(DEPTH);
  localparam logic [63:0] BASE   = 64'h0;
  localparam logic [31:0] NOP    = 32'h00000013;

  logic              clk = 1'b0;
  logic              reset;
  logic              ld_start;
  logic [ADDR_W:0]   ld_count;
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_ready;
  logic              busy;
  logic              core_reset;
  logic [63:0]       imem_addr;
  logic [31:0]       imem_rdata;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic              ld_error;
`endif

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .NOP_INSN(NOP)) dut (
    .clk        (clk),
    .reset      (reset),
    .ld_start   (ld_start),
    .ld_count   (ld_count),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_ready   (ld_ready),
    .busy       (busy),
    .core_reset (core_reset),
`ifdef IMEM_LOAD_CHECKSUM_EN
    .ld_error   (ld_error),
`endif
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata)
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model_mem [DEPTH];
  bit          model_run;
  logic [31:0] buf_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_fetch(input logic [63:0] a);
    logic [63:0] o;
    o = a - BASE;
    if (!model_run || (o % 4) != 0 || (o / 4) >= 64'(DEPTH)) return NOP;
    return model_mem[int'(o / 4)];
  endfunction

  function automatic logic [63:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return BASE + 64'(4 * $urandom_range(0, DEPTH-1));
      1:       return BASE + 64'(4 * $urandom_range(0, DEPTH-1) + $urandom_range(1, 3));
      2:       return BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 1000));
      default: return BASE - 64'(4 * $urandom_range(1, 1000));
    endcase
  endfunction

  task automatic fetch_chk(input string tag, input logic [63:0] a);
    @(negedge clk);
    imem_addr = a;
    #1;
    check(tag, imem_rdata, model_fetch(a));
  endtask

  // mode: 0 = valid held high, 1 = valid toggles 1/0, 2 = random valid
  task automatic do_load(input int n, input int mode, input bit bad_sum);
    int          len, acc, cyc;
    bit          v, tog, exp_run;
    logic [31:0] sum;
    len = (n > DEPTH) ? DEPTH : n;
    while (buf_q.size() < len) buf_q.push_back($urandom);
    @(negedge clk);
    ld_start = 1'b1;
    ld_count = n[ADDR_W:0];
    ld_valid = 1'b0;
    @(negedge clk);
    ld_start = 1'b0;
    ld_count = (ADDR_W+1)'($urandom);
    model_run = 1'b0;
    acc = 0; cyc = 0; tog = 1'b1; sum = '0;
    while (acc < len && cyc < 3*DEPTH + 50) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
      tog = ~tog;
      ld_valid  = v;
      ld_data   = buf_q[acc];
      imem_addr = rand_addr();
      ld_start  = ($urandom_range(0, 7) == 0);
      #1;
      check("load_ready", ld_ready, 1);
      check("load_core_reset", core_reset, 1);
      check("load_busy", busy, 1);
      check("load_fetch_nop", imem_rdata, NOP);
      if (v) begin
        model_mem[acc] = buf_q[acc];
        sum += buf_q[acc];
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
    if (acc < len) check("load_timeout", acc, len);
    exp_run = 1'b1;
`ifdef IMEM_LOAD_CHECKSUM_EN
    ld_valid = 1'b1;
    ld_data  = sum + (bad_sum ? 32'd1 : 32'd0);
    #1;
    check("check_ready", ld_ready, 1);
    check("check_busy", busy, 1);
    check("check_core_reset", core_reset, 1);
    @(negedge clk);
    ld_valid = 1'b0;
    exp_run = !bad_sum;
`else
    if (bad_sum) check("bad_sum_unsupported", 0, 1);
`endif
    #1;
    check("done_core_reset", core_reset, !exp_run);
    check("done_ready", ld_ready, 0);
    check("done_busy", busy, 0);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("done_ld_error", ld_error, !exp_run);
`endif
    model_run = exp_run;
    ld_valid = 1'b1;
    ld_data  = $urandom;
    @(negedge clk);
    #1;
    check("post_ready", ld_ready, 0);
    ld_valid = 1'b0;
    buf_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; ld_start = 1'b0; ld_count = '0; ld_valid = 1'b0;
    ld_data = '0; imem_addr = '0; model_run = 1'b0;
    #12;
    check("rst_core_reset", core_reset, 1);
    check("rst_ready", ld_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fetch", imem_rdata, NOP);
`ifdef IMEM_LOAD_CHECKSUM_EN
    check("rst_ld_error", ld_error, 0);
`endif
    @(negedge clk);
    reset = 1'b1;
    fetch_chk("idle_fetch", 64'h0);

    // Oversized count: exactly DEPTH words land, last one at 4*(DEPTH-1).
    do_load(DEPTH + 1, 0, 0);
    fetch_chk("depth_last", BASE + 64'(4 * (DEPTH-1)));
    fetch_chk("depth_first", BASE);

    buf_q = '{32'h00500093, 32'h00600113, 32'h002081B3, 32'h0000006F};
    do_load(4, 0, 0);
    fetch_chk("fetch_0x8", BASE + 64'h8);
    check("fetch_0x8_const", imem_rdata, 32'h002081B3);
    fetch_chk("misaligned", BASE + 64'h2);
    check("misaligned_const", imem_rdata, NOP);
    fetch_chk("beyond_depth", BASE + 64'(4 * DEPTH));
    fetch_chk("below_base", BASE - 64'h4);

    do_load(3, 1, 0);
    for (int i = 0; i < 3; i++) fetch_chk("toggle_word", BASE + 64'(4 * i));

    // Reset pulsed after two of five words.
    buf_q = '{$urandom, $urandom, $urandom, $urandom, $urandom};
    @(negedge clk); ld_start = 1'b1; ld_count = 5;
    @(negedge clk); ld_start = 1'b0; ld_valid = 1'b1; ld_data = buf_q[0];
    model_run = 1'b0;
    @(negedge clk); ld_data = buf_q[1];
    @(negedge clk); ld_valid = 1'b0;
    model_mem[0] = buf_q[0];
    model_mem[1] = buf_q[1];
    #1 reset = 1'b0;
    #1;
    check("midrst_core_reset", core_reset, 1);
    check("midrst_ready", ld_ready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_fetch", imem_rdata, NOP);
    @(negedge clk); reset = 1'b1;
    #1 check("midrst_idle_ready", ld_ready, 0);
    fetch_chk("midrst_idle_fetch", BASE);
    buf_q.delete();
    do_load(5, 2, 0);
    for (int i = 0; i < 5; i++) fetch_chk("reload_word", BASE + 64'(4 * i));

    do_load(0, 0, 0);
    fetch_chk("zero_load_fetch", BASE + 64'h4);

    repeat (6) begin
      do_load($urandom_range(1, 20), 2, 0);
      repeat (8) fetch_chk("rand_fetch", rand_addr());
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    buf_q = '{32'd1, 32'd2, 32'd3};
    do_load(3, 0, 0);
    fetch_chk("sum_ok_fetch", BASE + 64'h8);
    buf_q = '{32'd1, 32'd2, 32'd3};
    do_load(3, 0, 1);
    fetch_chk("sum_err_fetch", BASE);
    check("sum_err_flag", ld_error, 1);
    check("sum_err_core_reset", core_reset, 1);
    buf_q = '{32'd1, 32'd2, 32'd3};
    do_load(3, 0, 0);
    fetch_chk("sum_recover_fetch", BASE + 64'h4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
